// File: rtl/wb_result_stage_if.sv
// Bundle between the execute/memory boundary and the writeback stage: instruction
// handshake, memory read return, and the register-file/forwarding result bus.
interface wb_result_stage_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ResultSrc;
  logic [XLEN-1:0] ALUResult;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] ImmExt;
  logic [XLEN-1:0] PCTarget;
  logic [4:0]      rd;
  logic            RegWrite;
  logic [2:0]      LoadFunct3;
  logic            mem_rvalid;
  logic [XLEN-1:0] MemoryData;
  logic            wb_valid;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  modport master (
    output in_valid, ResultSrc, ALUResult, PCPlus4, ImmExt, PCTarget,
           rd, RegWrite, LoadFunct3, mem_rvalid, MemoryData,
    input  in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_err
  );

  modport slave (
    input  in_valid, ResultSrc, ALUResult, PCPlus4, ImmExt, PCTarget,
           rd, RegWrite, LoadFunct3, mem_rvalid, MemoryData,
    output in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/wb_result_stage.sv
// Registered writeback stage: selects the result source, parks loads until memory
// data returns, then extracts/extends and alignment-checks the loaded value.
module wb_result_stage #(
  parameter int XLEN        = 32,
  parameter bit LOAD_EXT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_result_stage_if.slave bus
);

  localparam logic [2:0] SRC_LOAD = 3'b001;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            ld_regwrite_q, ld_regwrite_d;
  logic [2:0]      ld_funct3_q, ld_funct3_d;
  logic [2:0]      ld_off_q, ld_off_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_we_q, wb_we_d;
  logic            wb_err_q, wb_err_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            src_err;
  logic            ld_err;

  function automatic logic src_illegal(input logic [2:0] src);
    return src[2] && (src[1:0] != 2'b00);
  endfunction

  function automatic logic [XLEN-1:0] select_src(
    input logic [2:0]      src,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pct
  );
    logic [XLEN-1:0] res;
    case (src)
      3'b000:  res = alu;
      3'b010:  res = pc4;
      3'b011:  res = imm;
      3'b100:  res = pct;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Offset is already reduced to the lanes that exist for this XLEN.
  function automatic logic load_illegal(input logic [2:0] f3, input logic [2:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off[1:0] != 2'b00);
      3'b110:         bad = (XLEN == 32) || (off[1:0] != 2'b00);
      3'b011:         bad = (XLEN == 32) || (off != 3'b000);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [XLEN-1:0] extract_load(
    input logic [2:0]      f3,
    input logic [2:0]      off,
    input logic [XLEN-1:0] mem
  );
    logic [63:0] wide;
    logic [63:0] sh;
    logic [63:0] r;
    wide = 64'(mem);
    sh   = wide >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   r = f3[2] ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'b01:   r = f3[2] ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'b10:   r = f3[2] ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r[XLEN-1:0];
  endfunction

  assign bus.in_ready = (state_q == S_IDLE);
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_err   = wb_err_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

  always_comb begin
    state_d       = state_q;
    ld_rd_d       = ld_rd_q;
    ld_regwrite_d = ld_regwrite_q;
    ld_funct3_d   = ld_funct3_q;
    ld_off_d      = ld_off_q;
    wb_valid_d    = 1'b0;
    wb_we_d       = 1'b0;
    wb_err_d      = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    src_err       = 1'b0;
    ld_err        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.ResultSrc == SRC_LOAD) begin
            ld_rd_d       = bus.rd;
            ld_regwrite_d = bus.RegWrite;
            ld_funct3_d   = bus.LoadFunct3;
            ld_off_d      = (XLEN == 32) ? {1'b0, bus.ALUResult[1:0]} : bus.ALUResult[2:0];
            state_d       = S_WAIT_MEM;
          end else begin
            src_err    = src_illegal(bus.ResultSrc);
            wb_valid_d = 1'b1;
            wb_err_d   = src_err;
            wb_we_d    = bus.RegWrite && (bus.rd != 5'd0) && !src_err;
            wb_rd_d    = bus.rd;
            wb_data_d  = select_src(bus.ResultSrc, bus.ALUResult, bus.PCPlus4,
                                    bus.ImmExt, bus.PCTarget);
          end
        end
      end
      S_WAIT_MEM: begin
        // Memory data is only consumed from here, so a return in the accept cycle is dropped.
        if (bus.mem_rvalid) begin
          ld_err     = LOAD_EXT_EN && load_illegal(ld_funct3_q, ld_off_q);
          wb_valid_d = 1'b1;
          wb_err_d   = ld_err;
          wb_we_d    = ld_regwrite_q && (ld_rd_q != 5'd0) && !ld_err;
          wb_rd_d    = ld_rd_q;
          wb_data_d  = (!LOAD_EXT_EN || ld_err) ? bus.MemoryData
                                                : extract_load(ld_funct3_q, ld_off_q, bus.MemoryData);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ld_rd_q       <= 5'd0;
      ld_regwrite_q <= 1'b0;
      ld_funct3_q   <= 3'd0;
      ld_off_q      <= 3'd0;
      wb_valid_q    <= 1'b0;
      wb_we_q       <= 1'b0;
      wb_err_q      <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ld_rd_q       <= ld_rd_d;
      ld_regwrite_q <= ld_regwrite_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_off_q      <= ld_off_d;
      wb_valid_q    <= wb_valid_d;
      wb_we_q       <= wb_we_d;
      wb_err_q      <= wb_err_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
    end
  end

endmodule
